// File: rtl/eth_phy_pkg.sv
// eth_phy_pkg
//   Shared definitions for the Ethernet PHY link bring-up controller:
//   FSM state encoding (also the value driven on the 'state' output)
//   and saturation limits for the status counters.
package eth_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_LINK_UP   = 3'd3,
    ST_RESET_RX  = 3'd4,
    ST_FAULT     = 3'd5
  } link_state_e;

  localparam logic [7:0]  RETRY_SAT     = 8'hFF;
  localparam logic [15:0] LINK_DOWN_SAT = 16'hFFFF;

endpackage

// File: rtl/sync_signal.sv
// sync_signal
//   N-stage flop synchronizer for a bundle of independent level signals.
//   Each bit is synchronized on its own; no coherency between bits.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage
//   din   - asynchronous inputs
//   dout  - synchronized outputs (N cycles latency)
module sync_signal #(
  parameter int WIDTH = 4,
  parameter int N     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[N-1];

endmodule

// File: rtl/eth_phy_link_ctrl.sv
// eth_phy_link_ctrl
//   Per-lane link bring-up sequencer between a transceiver wrapper's
//   status outputs and its RX datapath reset. Waits for TX/RX reset done,
//   qualifies block lock (lock without high BER) for LOCK_STABLE cycles,
//   and pulses the RX datapath reset when lock does not arrive within
//   LOCK_TIMEOUT cycles. After MAX_RETRIES consecutive failed attempts it
//   parks in FAULT until enable is dropped.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   enable              - bring-up enable; low forces IDLE
//   tx_reset_done, rx_reset_done, rx_block_lock, rx_high_ber
//                       - asynchronous GT status, synchronized internally
//   rx_reset_req        - GT RX datapath reset request
//   link_up, fault      - link status
//   state               - current FSM state
//   retry_count         - consecutive failed lock attempts (sat. 255)
//   link_down_count     - LINK_UP losses of lock since reset (sat. 65535)
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | disabled; retry_count held at 0
// WAIT_DONE   | waiting for TX and RX reset done
// WAIT_LOCK   | counting qualified-lock cycles against the timeout
// LINK_UP     | link qualified; watching for lock loss / done drop
// RESET_RX    | rx_reset_req pulse of RESET_CYCLES cycles
// FAULT       | too many failed attempts; exit only via enable=0
module eth_phy_link_ctrl
  import eth_phy_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int RESET_CYCLES = 16,
  parameter int MAX_RETRIES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tx_reset_done,
  input  logic        rx_reset_done,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  output logic        rx_reset_req,
  output logic        link_up,
  output logic        fault,
  output logic [2:0]  state,
  output logic [7:0]  retry_count,
  output logic [15:0] link_down_count
);

  // One extra bit of headroom so every limit is representable and the
  // counters never wrap before the compare fires.
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int RST_W = $clog2(RESET_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_DONE    = STB_W'(LOCK_STABLE);
  localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RESET_CYCLES - 1);
  localparam logic [31:0]      RETRY_LIMIT = 32'(MAX_RETRIES);

  logic [3:0]       sts_sync;
  logic             tx_done_s;
  logic             rx_done_s;
  logic             lock_s;
  logic             ber_s;
  logic             done_ok;
  logic             lock_ok;

  link_state_e      state_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [STB_W-1:0] stb_cnt;
  logic [STB_W-1:0] stb_next;
  logic [RST_W-1:0] rst_cnt;

  sync_signal #(
    .WIDTH (4),
    .N     (2)
  ) u_sts_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({rx_high_ber, rx_block_lock, rx_reset_done, tx_reset_done}),
    .dout  (sts_sync)
  );

  assign tx_done_s = sts_sync[0];
  assign rx_done_s = sts_sync[1];
  assign lock_s    = sts_sync[2];
  assign ber_s     = sts_sync[3];
  assign done_ok   = tx_done_s & rx_done_s;
  assign lock_ok   = lock_s & ~ber_s;

  // Stable count including this cycle; used so LINK_UP is reached after
  // exactly LOCK_STABLE qualified cycles spent in WAIT_LOCK.
  assign stb_next  = lock_ok ? stb_cnt + 1'b1 : '0;

  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rx_reset_req    <= 1'b0;
      link_up         <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= '0;
      link_down_count <= '0;
      tmo_cnt         <= '0;
      stb_cnt         <= '0;
      rst_cnt         <= '0;
    end else if (!enable) begin
      // link_down_count deliberately survives a disable.
      state_q      <= ST_IDLE;
      rx_reset_req <= 1'b0;
      link_up      <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_WAIT_DONE;
          retry_count <= '0;
        end

        ST_WAIT_DONE: begin
          if (done_ok) begin
            state_q <= ST_WAIT_LOCK;
            tmo_cnt <= '0;
            stb_cnt <= '0;
          end
        end

        ST_WAIT_LOCK: begin
          if (!done_ok) begin
            state_q <= ST_WAIT_DONE;
          end else begin
            stb_cnt <= stb_next;
            tmo_cnt <= tmo_cnt + 1'b1;
            // Lock completion is checked first so it wins a tie with timeout.
            if (stb_next == STB_DONE) begin
              state_q     <= ST_LINK_UP;
              link_up     <= 1'b1;
              retry_count <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
              state_q      <= ST_RESET_RX;
              rx_reset_req <= 1'b1;
              rst_cnt      <= RST_LAST;
              if (retry_count != RETRY_SAT) retry_count <= retry_count + 8'd1;
            end
          end
        end

        ST_LINK_UP: begin
          if (!done_ok) begin
            state_q <= ST_WAIT_DONE;
            link_up <= 1'b0;
          end else if (!lock_ok) begin
            // Relock is a fresh attempt: timeout and stable count restart.
            state_q <= ST_WAIT_LOCK;
            link_up <= 1'b0;
            tmo_cnt <= '0;
            stb_cnt <= '0;
            if (link_down_count != LINK_DOWN_SAT)
              link_down_count <= link_down_count + 16'd1;
          end
        end

        ST_RESET_RX: begin
          if (rst_cnt == '0) begin
            rx_reset_req <= 1'b0;
            if ({24'd0, retry_count} >= RETRY_LIMIT) begin
              state_q <= ST_FAULT;
              fault   <= 1'b1;
            end else begin
              state_q <= ST_WAIT_DONE;
            end
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end

        ST_FAULT: begin
          state_q <= ST_FAULT;
        end

        default: begin
          state_q      <= ST_IDLE;
          rx_reset_req <= 1'b0;
          link_up      <= 1'b0;
          fault        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/eth_phy_link_ctrl.md
ETH_PHY_LINK_CTRL -- requirements
Module: eth_phy_link_ctrl

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 65536, meaning cycles allowed in WAIT_LOCK before an RX datapath reset.
REQ-002 SHALL have parameter LOCK_STABLE, default 1024, meaning consecutive qualified-lock cycles required for link up.
REQ-003 SHALL have parameter RESET_CYCLES, default 16, meaning rx_reset_req pulse length in cycles.
REQ-004 SHALL have parameter MAX_RETRIES, default 8, meaning consecutive failed lock attempts before FAULT.
REQ-005 SHALL have ports: clk in 1, the single clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: enable in 1, link bring-up enable; tx_reset_done in 1; rx_reset_done in 1; rx_block_lock in 1; rx_high_ber in 1, where all four status inputs are asynchronous to clk.
REQ-007 SHALL have ports: rx_reset_req out 1, drives the GT RX datapath reset; link_up out 1; fault out 1; state out 3; retry_count out 8; link_down_count out 16.

Function
REQ-008 SHALL pass all four status inputs through a 2-flop synchronizer (2-cycle latency) before use; "lock_ok" denotes synchronized rx_block_lock=1 and rx_high_ber=0.
REQ-009 SHALL implement states IDLE=0, WAIT_DONE=1, WAIT_LOCK=2, LINK_UP=3, RESET_RX=4, FAULT=5, registered and output on state.
REQ-010 SHALL move from any state to IDLE on the cycle after enable=0; this has priority over every other transition.
REQ-011 IDLE: SHALL go to WAIT_DONE when enable=1, and SHALL clear retry_count on entry.
REQ-012 WAIT_DONE: SHALL go to WAIT_LOCK when both synchronized done inputs=1, clearing the timeout and stable counters.
REQ-013 WAIT_LOCK: SHALL count lock_ok cycles (count reset to 0 on any non-lock_ok cycle) and SHALL go to LINK_UP when the count reaches LOCK_STABLE.
REQ-014 WAIT_LOCK: SHALL increment the timeout counter every cycle and, when it reaches LOCK_TIMEOUT-1 without link up, SHALL go to RESET_RX; if both events occur in the same cycle, LINK_UP wins.
REQ-015 WAIT_LOCK or LINK_UP: SHALL go to WAIT_DONE when either synchronized done input drops, taking precedence over lock events.
REQ-016 LINK_UP: link_up=1 (registered); SHALL clear retry_count; on lock_ok=0 SHALL go to WAIT_LOCK and increment link_down_count (saturating at 65535).
REQ-017 RESET_RX: SHALL assert rx_reset_req for exactly RESET_CYCLES cycles and increment retry_count (saturating at 255) once on entry; it SHALL then go to FAULT if retry_count >= MAX_RETRIES, otherwise to WAIT_DONE.
REQ-018 FAULT: fault=1, rx_reset_req=0, link_up=0; SHALL exit only via enable=0 (REQ-010).
REQ-019 SHALL drive rx_reset_req=1 only in RESET_RX and link_up=1 only in LINK_UP; all outputs SHALL be registered.
REQ-020 SHALL size counters with $clog2 of their limits, and SHALL evaluate comparisons at full width with no wrap.

Reset
REQ-021 While rst_n=0: state=IDLE, rx_reset_req=0, link_up=0, fault=0, retry_count=0, link_down_count=0, and all counters and synchronizer flops=0.
REQ-022 Reset deassertion SHALL be synchronized to clk by the integrator; reset mid-pulse SHALL drop rx_reset_req immediately.
REQ-023 link_down_count SHALL clear only on rst_n, not when enable=0.

Structure
REQ-024 State encodings SHALL live in shared package eth_phy_pkg; parameters remain module-local.
REQ-025 SHALL instantiate one sub-module, sync_signal (WIDTH=4, N=2), for the status inputs; the FSM and counters are in the top module.
REQ-026 SHALL be placed between the transceiver wrapper status outputs and its RX datapath reset input, one instance per lane.

Verification (LOCK_TIMEOUT=16, LOCK_STABLE=4, RESET_CYCLES=3, MAX_RETRIES=2)
REQ-027 Scenario: dones=1, lock_ok held, enable rises -> link_up=1 within 2+1+1+4+1 cycles; rx_reset_req never asserted.
REQ-028 Scenario: dones=1, lock=0 -> rx_reset_req high exactly 3 cycles after 16 WAIT_LOCK cycles; retry_count=1; second failure -> retry_count=2, state=FAULT, fault=1; enable=0 -> IDLE, retry_count=0 upon next enable.
REQ-029 Scenario: in LINK_UP, rx_high_ber pulses 1 cycle -> link_up falls, link_down_count=1, relock after 4 stable cycles.
REQ-030 Scenario: lock toggles every 3 cycles in WAIT_LOCK -> no LINK_UP, RESET_RX at timeout.
REQ-031 Scenario: rst_n asserted during RESET_RX cycle 2 -> rx_reset_req=0 asynchronously, all outputs at reset values.
REQ-032 Scenario: rx_reset_done drops in LINK_UP -> WAIT_DONE, link_up=0, link_down_count unchanged.
